// File: rtl/object_manager.sv
// object_manager
// Owns up to five collectable/enemy slots for the display pipeline. Game logic
// spawns and collects objects. Once per video frame (the first cycle vsync is
// low), every live object scrolls left by SPEED, advances its animation frame
// every FRAME_DIV frames, and retires when it would leave the screen. A single
// pending spawn request is serviced on the frame tick.
//
// Ports:
//   vclock       pixel clock, sole clock
//   reset        asynchronous active-high reset, clears all control state
//   vsync        active-low vertical sync, synchronous to vclock
//   spawn        one-cycle spawn request with spawn_type / spawn_vpos
//   collect      one-cycle removal request for slot collect_idx (0..4)
//   p_obj1..5    slot 0..4 packed {frame[2:0], id[1:0], hpos[10:0], vpos[9:0]},
//                zero when the slot is empty
//   obj_count    number of live slots
//   spawn_drop   one-cycle pulse, one cycle after a spawn request is discarded
module object_manager #(
  parameter int SPEED      = 2,
  parameter int FRAME_DIV  = 4,
  parameter int NUM_FRAMES = 6,
  parameter int SPAWN_X    = 1023
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        spawn,
  input  logic [1:0]  spawn_type,
  input  logic [9:0]  spawn_vpos,
  input  logic        collect,
  input  logic [2:0]  collect_idx,
  output logic [25:0] p_obj1,
  output logic [25:0] p_obj2,
  output logic [25:0] p_obj3,
  output logic [25:0] p_obj4,
  output logic [25:0] p_obj5,
  output logic [2:0]  obj_count,
  output logic        spawn_drop
);

  localparam logic [10:0] SPEED_V    = 11'(SPEED);
  localparam logic [3:0]  DIV_LAST   = 4'(FRAME_DIV - 1);
  localparam logic [2:0]  FRAME_LAST = 3'(NUM_FRAMES - 1);
  localparam logic [10:0] SPAWN_XV   = 11'(SPAWN_X);

  // Control state (reset)
  logic        vsync_d;
  logic [3:0]  anim_cnt;
  logic        pending;
  logic [4:0]  valid;

  // Slot and request payload (not reset; qualified by valid / pending)
  logic [2:0]  frame [5];
  logic [1:0]  id    [5];
  logic [10:0] hpos  [5];
  logic [9:0]  vpos  [5];
  logic [1:0]  pend_type;
  logic [9:0]  pend_vpos;

  // Next-state
  logic        tick;
  logic        step;
  logic [4:0]  hit;
  logic [3:0]  anim_nx;
  logic        pending_nx;
  logic        drop_nx;
  logic [4:0]  valid_nx;
  logic [2:0]  frame_nx [5];
  logic [1:0]  id_nx    [5];
  logic [10:0] hpos_nx  [5];
  logic [9:0]  vpos_nx  [5];
  logic [1:0]  pend_type_nx;
  logic [9:0]  pend_vpos_nx;
  logic [2:0]  count_nx;
  logic        found;

  always_comb begin
    tick = vsync_d & ~vsync;
    step = tick && (anim_cnt == DIV_LAST);

    anim_nx = anim_cnt;
    if (tick) anim_nx = step ? 4'd0 : anim_cnt + 4'd1;

    pending_nx   = pending;
    drop_nx      = 1'b0;
    pend_type_nx = pend_type;
    pend_vpos_nx = pend_vpos;
    found        = 1'b0;
    count_nx     = 3'd0;

    for (int i = 0; i < 5; i++) begin
      hit[i]      = collect && (collect_idx == 3'(i));
      valid_nx[i] = valid[i] & ~hit[i];
      frame_nx[i] = frame[i];
      id_nx[i]    = id[i];
      hpos_nx[i]  = hpos[i];
      vpos_nx[i]  = vpos[i];
    end

    // Scroll / animate / expire surviving objects on the frame tick
    if (tick) begin
      for (int i = 0; i < 5; i++) begin
        if (valid[i] && !hit[i]) begin
          if (hpos[i] <= SPEED_V) begin
            valid_nx[i] = 1'b0;
          end else begin
            hpos_nx[i] = hpos[i] - SPEED_V;
            if (step) frame_nx[i] = (frame[i] == FRAME_LAST) ? 3'd0 : frame[i] + 3'd1;
          end
        end
      end
    end

    // Service the pending spawn. A slot freed by this tick's expiry is not
    // eligible, but a slot being collected this cycle is.
    if (tick && pending) begin
      for (int i = 0; i < 5; i++) begin
        if (!found && (!valid[i] || hit[i])) begin
          found       = 1'b1;
          valid_nx[i] = 1'b1;
          frame_nx[i] = 3'd0;
          id_nx[i]    = pend_type;
          hpos_nx[i]  = SPAWN_XV;
          vpos_nx[i]  = pend_vpos;
        end
      end
      if (!found) drop_nx = 1'b1;
      pending_nx = 1'b0;
    end

    // A tick always empties the pending register, so a request arriving on a
    // tick cycle is latched and waits for the following tick.
    if (spawn) begin
      if (!pending || tick) begin
        pending_nx   = 1'b1;
        pend_type_nx = spawn_type;
        pend_vpos_nx = spawn_vpos;
      end else begin
        drop_nx = 1'b1;
      end
    end

    for (int i = 0; i < 5; i++) count_nx = count_nx + {2'b00, valid_nx[i]};
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      vsync_d    <= 1'b1;
      anim_cnt   <= 4'd0;
      pending    <= 1'b0;
      valid      <= 5'b0;
      obj_count  <= 3'd0;
      spawn_drop <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      anim_cnt   <= anim_nx;
      pending    <= pending_nx;
      valid      <= valid_nx;
      obj_count  <= count_nx;
      spawn_drop <= drop_nx;
    end
  end

  always_ff @(posedge vclock) begin
    pend_type <= pend_type_nx;
    pend_vpos <= pend_vpos_nx;
    for (int i = 0; i < 5; i++) begin
      frame[i] <= frame_nx[i];
      id[i]    <= id_nx[i];
      hpos[i]  <= hpos_nx[i];
      vpos[i]  <= vpos_nx[i];
    end
  end

  assign p_obj1 = valid[0] ? {frame[0], id[0], hpos[0], vpos[0]} : 26'b0;
  assign p_obj2 = valid[1] ? {frame[1], id[1], hpos[1], vpos[1]} : 26'b0;
  assign p_obj3 = valid[2] ? {frame[2], id[2], hpos[2], vpos[2]} : 26'b0;
  assign p_obj4 = valid[3] ? {frame[3], id[3], hpos[3], vpos[3]} : 26'b0;
  assign p_obj5 = valid[4] ? {frame[4], id[4], hpos[4], vpos[4]} : 26'b0;

endmodule

// File: doc/object_manager.md
# object_manager

Producer of the five packed object words consumed by the display pipeline. Holds up to five collectable/enemy slots and accepts spawn and collect requests from game logic. Once per video frame it scrolls every live object left, advances its animation frame and retires objects that leave the screen. Outputs change only just after the start of vertical sync, so the display's per-frame latch always sees a coherent set.

## Interface
Parameters:
- SPEED, 2: pixels each object moves left per frame (1..15).
- FRAME_DIV, 4: frame ticks per animation-frame step (1..15).
- NUM_FRAMES, 6: animation frames per object; frame field wraps NUM_FRAMES-1 -> 0 (1..8).
- SPAWN_X, 1023: horizontal position given to a newly spawned object (> SPEED).

Ports:
- vclock  in  1: 65 MHz pixel clock; sole clock.
- reset  in  1: asynchronous, active-high; clears all state.
- vsync  in  1: active-low vertical sync from the xvga generator, synchronous to vclock.
- spawn  in  1: one-cycle spawn request.
- spawn_type  in  2: identity for the spawned object (0 = coin).
- spawn_vpos  in  10: vertical position for the spawned object.
- collect  in  1: one-cycle request to remove a slot (pickup or hit).
- collect_idx  in  3: slot index 0..4 to remove; 5..7 ignored.
- p_obj1..p_obj5  out  26 each: slot 0..4 packed as [25:23] frame, [22:21] identity, [20:10] hpos, [9:0] vpos; 26'b0 when the slot is empty.
- obj_count  out  3: number of valid slots, 0..5.
- spawn_drop  out  1: one-cycle pulse when a spawn request is discarded.

## Operation
- Per-slot state: valid, frame[2:0], id[1:0], hpos[10:0], vpos[9:0]. A packed output is the slot fields when valid, else 26'b0.
- A valid slot always has hpos >= 1, so a live object never packs to 26'b0.
- Frame tick: vsync_d is vsync registered; tick = vsync_d & ~vsync, i.e. the first cycle vsync is low. vsync_d resets to 1.
- Animation divider anim_cnt counts ticks 0..FRAME_DIV-1. On the tick where anim_cnt == FRAME_DIV-1, anim_cnt returns to 0 and step = 1.
- On tick, for each valid slot not being collected in the same cycle:
  - if hpos <= SPEED: valid <= 0 (expired);
  - else hpos <= hpos - SPEED, and if step: frame <= (frame == NUM_FRAMES-1) ? 0 : frame + 1.
- Spawn pending register (one deep):
  - spawn with no request pending: latch type and vpos, set pending.
  - spawn while already pending: new request discarded, spawn_drop pulses next cycle.
  - spawn and tick in the same cycle: the new request is latched and is serviced on the following tick.
- Spawn service on tick:
  - Pick the lowest-index slot that is invalid at the start of the tick cycle or is being collected in that cycle. Slots that expire on this tick do not count as free.
  - Load that slot with valid=1, frame=0, id=type, hpos=SPAWN_X, vpos, and clear pending.
  - If no slot is free: discard the request, clear pending, pulse spawn_drop.
- Collect: takes effect on the next clock edge regardless of tick; clears valid for collect_idx. Collecting an already-empty slot has no effect.
- obj_count is a registered popcount of the valid bits, updated with them.
- Reset:
  - All slots invalid, so all p_obj outputs are 0.
  - obj_count = 0, spawn_drop = 0, pending = 0, anim_cnt = 0, vsync_d = 1.
  - Reset asserted mid-frame discards all slots and pending requests immediately.

## Timing
- All outputs are registered.
- Slot updates from a tick are visible on p_obj one cycle after the tick cycle, i.e. the second vclock edge after vsync falls.
- A frame-boundary latch in the consumer that samples at the vsync falling edge therefore sees the previous frame's values. This gives one frame of latency by design.
- Collect: the slot reads 0 one cycle after the collect cycle.
- Spawn: the object appears one cycle after the first tick that follows the request; worst case this is one full frame later.
- spawn_drop is high for exactly one cycle, one cycle after the dropping event.
- Outputs are constant between ticks except for collect-driven clears.

## Test plan
- Reset, then vsync toggling for 3 frames with no requests: all p_obj = 0, obj_count = 0, spawn_drop never high.
- spawn type=0, vpos=300, then one tick: p_obj1 = {3'd0, 2'd0, 11'd1023, 10'd300}, obj_count = 1.
  - After 4 more ticks: hpos = 1015, frame = 1.
  - After 24 ticks: frame has wrapped 5 -> 0.
- Object at hpos = 3 with SPEED = 2: next tick gives hpos = 1. The tick after that removes it and p_obj1 returns to 0.
- Fill all 5 slots, then spawn and tick: spawn_drop pulses once and slots are unchanged.
  - Then collect idx=2 in the same cycle as a tick with a spawn pending: slot 2 is reloaded with hpos = 1023, frame = 0.
- Two spawn pulses in one frame: first is serviced, second produces a spawn_drop pulse the cycle after it arrives.
- Assert reset mid-frame with 3 live objects: on the same cycle every p_obj = 0 and obj_count = 0, without waiting for a vclock edge.
